// File: rtl/sgfilter_pkg.sv
// Shared types and default widths for the sgfilter caller.
package sgfilter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int IDX_W_DEF  = 32;
  localparam int CNT_W_DEF  = 16;

  typedef logic [CNT_W_DEF-1:0] cnt_t;
  typedef logic [IDX_W_DEF-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sgfilter_caller_fifo.sv
// Synchronous result FIFO; DEPTH must be a power of two.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sgfilter_caller_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 33
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = AW'(DEPTH) == '0 ? (AW+1)'(DEPTH) : (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sgfilter_caller.sv
// Sweep initiator for the sgfilter call/return interface.
// Optional feature macro: SGF_CALLER_CHECKSUM_EN adds a per-sweep XOR checksum output.
module sgfilter_caller
  import sgfilter_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int IDX_W           = IDX_W_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_base,
  input  logic [CNT_W-1:0]  req_count,
  output logic              call_start,
  input  logic              call_busy,
  output logic [IDX_W-1:0]  call_idx,
  input  logic              ret_done,
  output logic              ret_stall,
  input  logic [DATA_W-1:0] ret_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              sweep_done,
  output logic              err_unexpected
`ifdef SGF_CALLER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [OW-1:0]    OUT_ONE = OW'(1);
  localparam logic [FW-1:0]    FIFO_ONE = FW'(1);

  state_t            state, state_n;
  logic [IDX_W-1:0]  base_r, base_n;
  logic [CNT_W-1:0]  count_r, count_n;
  logic [CNT_W-1:0]  issued, issued_n;
  logic [CNT_W-1:0]  received;
  logic [CNT_W-1:0]  beats;
  logic [OW-1:0]     outstanding, outstanding_n;
  logic [FW-1:0]     fifo_count, fifo_count_n;
  logic              fifo_full, fifo_empty;
  logic [DATA_W:0]   fifo_rd;
  logic              accept, call_xfer, ret_xfer, ret_acc, ret_drop, pop;
  logic              done_n, start_n, credit_ok;

  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid;
  assign call_xfer = call_start && !call_busy;
  assign ret_stall = fifo_full && (outstanding != '0);
  assign ret_xfer  = ret_done && !ret_stall;
  assign ret_acc   = ret_xfer && (outstanding != '0);
  assign ret_drop  = ret_xfer && (outstanding == '0);
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rd[DATA_W-1:0];
  assign out_last  = out_valid && fifo_rd[DATA_W];
  assign pop       = out_valid && out_ready;

  sgfilter_caller_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (ret_acc),
    .wr_data ({(received == count_r - CNT_ONE), ret_data}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Sweep sequencing: next state and completion pulse.
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_count == '0) done_n = 1'b1;
          else                 state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (call_xfer && (issued + CNT_ONE == count_r)) state_n = DRAIN;
      end
      DRAIN: begin
        if ((received == count_r) && fifo_empty && (beats == count_r)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Post-cycle view of counters, so the registered call_start can issue back to back
  // while the credit check still sees this cycle's call, return and pop.
  always_comb begin
    base_n        = accept ? req_base : base_r;
    count_n       = accept ? req_count : count_r;
    issued_n      = accept ? '0 : issued + CNT_W'(call_xfer);
    outstanding_n = outstanding;
    unique case ({call_xfer, ret_acc})
      2'b10:   outstanding_n = outstanding + OUT_ONE;
      2'b01:   outstanding_n = outstanding - OUT_ONE;
      default: outstanding_n = outstanding;
    endcase
    fifo_count_n = fifo_count;
    unique case ({ret_acc, pop})
      2'b10:   fifo_count_n = fifo_count + FIFO_ONE;
      2'b01:   fifo_count_n = fifo_count - FIFO_ONE;
      default: fifo_count_n = fifo_count;
    endcase
    credit_ok = (int'(outstanding_n) < MAX_OUTSTANDING) &&
                (int'(outstanding_n) + int'(fifo_count_n) < FIFO_DEPTH);
    start_n   = (state_n == ISSUE) && (issued_n < count_n) && credit_ok;
  end

  // Call request registers; held stable while the component is busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      call_start <= 1'b0;
      call_idx   <= '0;
    end else if (!(call_start && call_busy)) begin
      call_start <= start_n;
      if (state_n == ISSUE) call_idx <= base_n + IDX_W'(issued_n);
    end
  end

  // State, sweep counters and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      base_r         <= '0;
      count_r        <= '0;
      issued         <= '0;
      received       <= '0;
      beats          <= '0;
      outstanding    <= '0;
      sweep_done     <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      state          <= state_n;
      base_r         <= base_n;
      count_r        <= count_n;
      issued         <= issued_n;
      received       <= accept ? '0 : received + CNT_W'(ret_acc);
      beats          <= accept ? '0 : beats + CNT_W'(pop);
      outstanding    <= outstanding_n;
      sweep_done     <= done_n;
      err_unexpected <= err_unexpected | ret_drop;
    end
  end

`ifdef SGF_CALLER_CHECKSUM_EN
  // Running XOR of delivered results for the current sweep.
  always_ff @(posedge clock) begin
    if (reset || accept) checksum <= '0;
    else if (pop)        checksum <= checksum ^ out_data;
  end
`endif

endmodule

// File: tb/tb_sgfilter_caller.sv
// Scoreboard bench for sgfilter_caller with a behavioural in-order component model.
module tb_sgfilter_caller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_base = '0;
  logic [15:0] req_count = '0;
  logic        call_start;
  logic        call_busy = 1'b0;
  logic [31:0] call_idx;
  logic        ret_done = 1'b0;
  logic        ret_stall;
  logic [31:0] ret_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        sweep_done;
  logic        err_unexpected;
`ifdef SGF_CALLER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clock = ~clock;

  sgfilter_caller #(
    .DATA_W          (32),
    .IDX_W           (32),
    .CNT_W           (16),
    .MAX_OUTSTANDING (4),
    .FIFO_DEPTH      (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_base       (req_base),
    .req_count      (req_count),
    .call_start     (call_start),
    .call_busy      (call_busy),
    .call_idx       (call_idx),
    .ret_done       (ret_done),
    .ret_stall      (ret_stall),
    .ret_data       (ret_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .sweep_done     (sweep_done),
    .err_unexpected (err_unexpected)
`ifdef SGF_CALLER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic [32:0] exp_out[$];
  logic [31:0] exp_idx[$];
  logic [31:0] exp_csum = '0;
  logic [31:0] pipe_idx[$];
  int unsigned pipe_due[$];
  int unsigned call_cyc[$];

  int   calls_in_sweep = 0;
  int   beats_seen = 0;
  int   done_cnt = 0;
  int   stall_seen = 0;
  int   ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
  int   fixed_lat = 1;    // 0 means random 1..6
  bit   rand_busy = 0;
  bit   busy_test = 0;
  bit   busy_done = 0;
  bit   inject_unexp = 0;

  function automatic logic [31:0] comp_f(input logic [31:0] idx);
    return (idx * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Component model: in-order pipeline with per-call latency, optional busy.
  initial begin : component
    bit          hold_v = 0;
    logic [31:0] hold_idx = '0;
    int          busy_left = 0;
    bit          injected;
    forever begin
      @(negedge clock);
      if (reset) begin
        pipe_idx.delete(); pipe_due.delete();
        call_busy = 0; ret_done = 0; hold_v = 0; busy_left = 0;
        continue;
      end
      if (hold_v) begin
        chk("hold_start", call_start, 1);
        chk("hold_idx", call_idx, hold_idx);
      end
      if (busy_left > 0) begin
        call_busy = 1; busy_left--;
      end else if (busy_test && !busy_done && call_start && calls_in_sweep == 1) begin
        call_busy = 1; busy_left = 2; busy_done = 1;
      end else begin
        call_busy = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      hold_v   = call_start && call_busy;
      hold_idx = call_idx;
      if (call_start && !call_busy) begin
        calls_in_sweep++;
        call_cyc.push_back(cyc);
        if (exp_idx.size() == 0) chk("call_extra", 1, 0);
        else                     chk("call_idx", call_idx, exp_idx.pop_front());
        pipe_idx.push_back(call_idx);
        pipe_due.push_back(cyc + ((fixed_lat != 0) ? fixed_lat : $urandom_range(1, 6)));
      end
      injected = 0;
      if (inject_unexp) begin
        ret_done = 1; ret_data = 32'hDEAD0001; inject_unexp = 0; injected = 1;
      end else if (pipe_idx.size() != 0 && pipe_due[0] <= cyc) begin
        ret_done = 1; ret_data = comp_f(pipe_idx[0]);
      end else begin
        ret_done = 0;
      end
      if (ret_stall) stall_seen++;
      if (ret_done && !ret_stall && !injected) begin
        void'(pipe_idx.pop_front()); void'(pipe_due.pop_front());
      end
    end
  end

  // Output monitor: pops the scoreboard on every delivered beat.
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin out_ready = 0; continue; end
      out_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        beats_seen++;
        if (exp_out.size() == 0) chk("out_extra", 1, 0);
        else begin
          e = exp_out.pop_front();
          chk("out_data", out_data, e[31:0]);
          chk("out_last", out_last, e[32]);
        end
      end
      if (sweep_done) begin
        done_cnt++;
`ifdef SGF_CALLER_CHECKSUM_EN
        chk("checksum", checksum, exp_csum);
`endif
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic issue_req(input logic [31:0] b, input logic [15:0] n);
    int          guard;
    logic [31:0] ix;
    guard = 0;
    while (!req_ready && guard < 2000) begin @(negedge clock); guard++; end
    if (!req_ready) chk("req_ready_timeout", req_ready, 1);
    req_base = b; req_count = n; req_valid = 1;
    exp_csum = '0;
    for (int i = 0; i < int'(n); i++) begin
      ix = b + 32'(i);
      exp_idx.push_back(ix);
      exp_out.push_back({(i == int'(n) - 1), comp_f(ix)});
      exp_csum ^= comp_f(ix);
    end
    calls_in_sweep = 0; call_cyc.delete(); busy_done = 0;
    @(negedge clock);
    req_valid = 0;
    if (n != 0) chk("req_ready_low", req_ready, 0);
  endtask

  task automatic wait_done(input int start);
    int g;
    g = 0;
    while (done_cnt <= start && g < 5000) begin @(negedge clock); g++; end
    if (done_cnt <= start) chk("sweep_done_timeout", done_cnt, start + 1);
  endtask

  initial begin : main
    int d0, b0;
    logic [15:0] n;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_call_start", call_start, 0);
    chk("rst_call_idx", call_idx, 0);
    chk("rst_ret_stall", ret_stall, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sweep_done", sweep_done, 0);
    chk("rst_err", err_unexpected, 0);
    idle(2);

    // Basic sweep: back-to-back calls, in-order results
    ready_mode = 1; fixed_lat = 1; rand_busy = 0;
    d0 = done_cnt;
    issue_req(32'd10, 16'd5);
    wait_done(d0);
    idle(4);
    chk("basic_calls", calls_in_sweep, 5);
    if (call_cyc.size() == 5) chk("basic_consecutive", call_cyc[4] - call_cyc[0], 4);
    else chk("basic_call_cnt", call_cyc.size(), 5);
    chk("basic_one_done", done_cnt - d0, 1);

    // Zero-length sweep
    d0 = done_cnt; b0 = beats_seen;
    issue_req(32'h55, 16'd0);
    wait_done(d0);
    idle(3);
    chk("zero_one_done", done_cnt - d0, 1);
    chk("zero_no_calls", calls_in_sweep, 0);
    chk("zero_no_beats", beats_seen - b0, 0);
    chk("zero_req_ready", req_ready, 1);

    // Index wrap
    d0 = done_cnt;
    issue_req(32'hFFFFFFFE, 16'd4);
    wait_done(d0);
    idle(2);
    chk("wrap_calls", calls_in_sweep, 4);

    // Consumer stalled: credit limit caps calls at FIFO depth
    fixed_lat = 0; ready_mode = 2;
    d0 = done_cnt;
    issue_req(32'd100, 16'd20);
    idle(150);
    chk("credit_calls", calls_in_sweep, 8);
    ready_mode = 1;
    wait_done(d0);
    idle(2);
    chk("credit_total_calls", calls_in_sweep, 20);
    chk("credit_all_beats", exp_out.size(), 0);

    // Busy held for 3 cycles on the second call
    busy_test = 1;
    d0 = done_cnt;
    issue_req(32'd500, 16'd6);
    wait_done(d0);
    idle(2);
    busy_test = 0;
    chk("busy_applied", busy_done, 1);
    chk("busy_calls", calls_in_sweep, 6);

    // Unexpected return while idle
    chk("unexp_before", err_unexpected, 0);
    inject_unexp = 1;
    idle(3);
    chk("unexp_set", err_unexpected, 1);
    chk("unexp_no_push", out_valid, 0);
    d0 = done_cnt;
    issue_req(32'd7, 16'd3);
    wait_done(d0);
    idle(2);
    chk("unexp_sticky", err_unexpected, 1);

    // Randomized sweeps
    rand_busy = 1; ready_mode = 0; fixed_lat = 0;
    for (int s = 0; s < 15; s++) begin
      n = 16'($urandom_range(0, 30));
      d0 = done_cnt;
      issue_req($urandom, n);
      wait_done(d0);
      idle($urandom_range(0, 3));
    end
    idle(5);
    chk("end_out_empty", exp_out.size(), 0);
    chk("end_idx_empty", exp_idx.size(), 0);
    chk("never_stalled", stall_seen, 0);

    // Reset clears the sticky error
    reset = 1;
    idle(2);
    reset = 0;
    chk("rst2_err", err_unexpected, 0);
    chk("rst2_req_ready", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
